// File: rtl/serial_adder.sv
// Bit-serial adder: adds two WIDTH-bit operands LSB-first through one full-adder cell.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.

module fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// Handshake: start is a level request sampled on each rising edge; it is accepted
// only in IDLE or DONE. done pulses for one cycle, and sum/cout stay valid until
// the next accepted start.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
`ifdef SERIAL_ADDER_OVF_EN
  logic               ovf_q, ovf_d;
`endif

  logic fa_s;
  logic fa_cout;

  fa u_fa (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
          ovf_d   = 1'b0;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = fa_cout;
        sum_d   = {fa_s, sum_q[WIDTH-1:1]};
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          // MSB edge: counter holds rather than wrapping.
          state_d = DONE;
          cout_d  = fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
          ovf_d   = carry_q ^ fa_cout;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): directed cases plus random operations
// checked against an arithmetic reference model through an expected-result queue.

module tb_serial_adder;

  localparam int WIDTH = 8;
  localparam int RW    = WIDTH + 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf_obs;

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf;
  assign ovf_obs = ovf;
`else
  assign ovf_obs = 1'b0;
`endif

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: {ovf, cout, sum} from plain integer arithmetic.
  function automatic logic [RW-1:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                          input logic ci);
    int u, sx, sy, ss;
    logic o;
    logic [RW-1:0] r;
    u  = int'(x) + int'(y) + int'(ci);
    sx = x[WIDTH-1] ? int'(x) - (1 << WIDTH) : int'(x);
    sy = y[WIDTH-1] ? int'(y) - (1 << WIDTH) : int'(y);
    ss = sx + sy + int'(ci);
`ifdef SERIAL_ADDER_OVF_EN
    o = (ss > (1 << (WIDTH - 1)) - 1) || (ss < -(1 << (WIDTH - 1)));
`else
    o = 1'b0;
`endif
    r = '0;
    r[WIDTH-1:0] = u[WIDTH-1:0];
    r[WIDTH]     = u[WIDTH];
    r[WIDTH+1]   = o;
    return r;
  endfunction

  // ---------------- scoreboard ----------------
  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] last_res = '0;
  int            done_cnt = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (busy || done) check("busy_done_excl", {31'd0, busy & done}, 32'd0);
      if (done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          last_res = exp_q.pop_front();
          check("result", {22'd0, ovf_obs, cout, sum}, {22'd0, last_res});
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Pulses start for one edge; returns at the first negedge after the accepting edge.
  task automatic start_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic ci);
    @(negedge clk);
    a = x; b = y; cin = ci; start = 1'b1;
    exp_q.push_back(model(x, y, ci));
    @(negedge clk);
    start = 1'b0;
    a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
    check("cleared_on_start", {23'd0, ovf_obs, cout, sum}, 32'd0);
  endtask

  // Counts observations (from the current negedge) until done; bounded.
  task automatic wait_done(output int obs, output int busy_cycles);
    obs = 0;
    busy_cycles = 0;
    while (!done && obs < 40) begin
      if (busy) busy_cycles++;
      @(negedge clk);
      obs++;
    end
    check("done_seen", {31'd0, done}, 32'd1);
  endtask

  task automatic run_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic ci);
    int obs, bc;
    start_op(x, y, ci);
    wait_done(obs, bc);
    check("latency", obs, WIDTH);
    check("busy_cycles", bc, WIDTH);
    @(negedge clk);
    check("done_pulse_one", {31'd0, done}, 32'd0);
    check("held_result", {22'd0, ovf_obs, cout, sum}, {22'd0, last_res});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int obs, bc, d0;
    logic [RW-1:0] r;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {27'd0, busy, done, ovf_obs, cout, |sum}, 32'd0);
    rst_n = 1'b1;

    // directed cases
    run_op(8'h00, 8'h00, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0);
    run_op(8'hFF, 8'hFF, 1'b1);
    run_op(8'h7F, 8'h01, 1'b0);
    run_op(8'h80, 8'h80, 1'b0);

    // start during RUN is ignored
    d0 = done_cnt;
    start_op(8'h12, 8'h34, 1'b1);
    @(negedge clk);
    @(negedge clk);
    a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(obs, bc);
    check("ignored_start_latency", obs, WIDTH - 3);
    check("ignored_start_sum", {23'd0, cout, sum}, 32'h047);
    repeat (12) @(negedge clk);
    check("ignored_start_one_done", done_cnt - d0, 1);

    // start held high: back-to-back operations
    d0 = done_cnt;
    @(negedge clk);
    a = 8'h0F; b = 8'h01; cin = 1'b0; start = 1'b1;
    exp_q.push_back(model(8'h0F, 8'h01, 1'b0));
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      wait_done(obs, bc);
      check("b2b_period", obs, WIDTH);
      check("b2b_busy", bc, WIDTH);
      check("b2b_sum", {24'd0, sum}, 32'h10);
      if (k < 2) exp_q.push_back(model(8'h0F, 8'h01, 1'b0));
      else start = 1'b0;
      @(negedge clk);
      if (k < 2) check("b2b_restart_busy", {31'd0, busy}, 32'd1);
    end
    repeat (3) @(negedge clk);
    check("b2b_done_count", done_cnt - d0, 3);

    // reset mid-operation
    d0 = done_cnt;
    start_op(8'hAA, 8'h55, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("mid_reset_outputs", {27'd0, busy, done, ovf_obs, cout, |sum}, 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("mid_reset_no_done", done_cnt - d0, 0);
    run_op(8'hAA, 8'h55, 1'b1);
    check("after_reset_sum", {23'd0, cout, sum}, 32'h100);

    // random operations with random idle gaps
    for (int i = 0; i < 40; i++) begin
      logic [WIDTH-1:0] x, y;
      logic ci;
      x  = WIDTH'($urandom);
      y  = WIDTH'($urandom);
      ci = 1'($urandom);
      if (i % 8 == 0) begin x = '1; y = '1; end
      r = model(x, y, ci);
      run_op(x, y, ci);
      check("rand_held_sum", {24'd0, sum}, {24'd0, r[WIDTH-1:0]});
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
